mem_bank: RTL
=============

# mem_bank

Parametrised, address-decoded RAM bank for the 6502 system bus, successor to the single-window memory. Adds address-window decode with mirroring, registered one-cycle reads with a valid strobe, a post-reset clear sequencer that fills the bank with a known value, and dynamic write protection with an error strobe. Several instances share the CPU data bus; each drives `dout` only while returning its own read data.

## Interface
Parameters:
- `WIDTH`, `REG_WIDTH` (8), data width.
- `ADDR_WIDTH`, `ADDR_WIDTH` (16), bus address width.
- `DEPTH`, 16, words per bank. Must be a power of two, ≥ 2.
- `BASE`, 0, first bus address of the window.
- `MIRRORS`, 1, number of consecutive DEPTH-sized copies decoded. ≥ 1.
- `INIT_VAL`, 0, value written to every word by the clear sequencer.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  write request.
- `re`  in  1  read request.
- `wp`  in  1  write protect. When 1, writes are dropped.
- `addr`  in  ADDR_WIDTH  bus address.
- `din`  in  WIDTH  write data.
- `dout`  out  WIDTH  read data. Driven when `valid`=1, otherwise all-Z.
- `valid`  out  1  read data on `dout` this cycle.
- `hit`  out  1  combinational: `addr` is inside the window.
- `busy`  out  1  clear sequencer running.
- `err`  out  1  one-cycle pulse on a rejected access.

## Operation
- Decode:
  - `hit` = (`addr` ≥ BASE) and (`addr` < BASE + DEPTH×MIRRORS). Compute this in ADDR_WIDTH+1 bits so the top of the window does not overflow.
  - Local index = (`addr` − BASE) mod DEPTH, taken as the low log2(DEPTH) bits of the difference.
- FSM states: CLEAR, IDLE.
  - Reset assertion (asynchronous): state=CLEAR, clear pointer=0, `busy`=1, `valid`=0, `err`=0, `dout`=Z.
  - CLEAR: each clock writes INIT_VAL to bank[ptr] and increments ptr. When ptr reaches DEPTH−1, the word is written and state moves to IDLE.
  - IDLE: normal accesses. IDLE never returns to CLEAR except through reset.
  - Reset asserted mid-clear or mid-access aborts immediately. The clear restarts from index 0 after release.
- Write: `we` & `hit` & IDLE & !`wp` → bank[local] ← `din` at the clock edge.
- Read: `re` & `hit` & IDLE → read register ← bank[local] at the edge. `valid`=1 for exactly the next cycle, with `dout` driving the register.
  - Back-to-back reads give back-to-back `valid` cycles.
- Simultaneous `re` and `we` to the same local index: read returns the old data (read-before-write). The write still occurs.
- Rejected access → `err` pulses for the cycle after the edge. No state change. Rejected means any of:
  - `we` & `hit` & `wp`.
  - (`we`|`re`) & `hit` while in CLEAR.
- Accesses with `hit`=0 are ignored silently: no `err`, no `valid`, `dout` stays Z.
- Mirrored addresses alias the same storage word.

## Timing
- Clear latency: the first edge after `reset_n` rises writes index 0. `busy` falls after DEPTH edges. An access presented on edge DEPTH+1 is accepted.
- Read latency: 1 cycle from request edge to `valid`/`dout`.
- Write latency: 0 cycles. Data is visible to a read requested on the next edge.
- `err` and `valid` are registered single-cycle pulses and are never both 1 for the same request.
- Output values during and immediately after reset:
  - `dout`: Z.
  - `valid`: 0.
  - `busy`: 1.
  - `err`: 0.
  - `hit`: follows `addr` combinationally, including during reset.

## Test plan
- Reset clear:
  - Stimulus: DEPTH=16, INIT_VAL=8'hA5; release reset and wait until `busy`=0, then read every index.
  - Required response: `busy` high for exactly 16 cycles; every read returns A5 with `valid` one cycle after `re`.
- Write/read and mirroring:
  - Stimulus: BASE=16'h0200, MIRRORS=4; write 8'h3C at 16'h0203, then read 16'h0213 and 16'h0233.
  - Required response: both reads return 3C; an access at 16'h0240 gives `hit`=0, `dout`=Z, no `err`.
- Protection and busy rejection:
  - Stimulus 1: `wp`=1, write 8'hFF to 16'h0205.
  - Required response 1: `err` pulses once; a subsequent read returns the prior value.
  - Stimulus 2: issue `re` during CLEAR.
  - Required response 2: `err` pulses; `valid` stays 0.
- Read-during-write:
  - Stimulus: index 7 holds 8'h11; assert `we` (din=8'h22) and `re` at index 7 in the same cycle.
  - Required response: `dout`=11 next cycle; a following read returns 22.
- Reset mid-clear:
  - Stimulus: assert `reset_n`=0 at clear index 9, then release.
  - Required response: `busy` is immediately 1 and clearing restarts at index 0; `busy` falls 16 cycles after release.

Source files
------------

// File: rtl/mem_bank_if.sv
// Bus-side signal bundle for one mem_bank instance.
// The CPU (or testbench) side takes the master modport, the bank takes slave.
// The shared read-data bus is not part of this bundle: it is a resolved net
// that several banks drive, so it stays a plain port on the bank.
interface mem_bank_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  we;     // write request
    logic                  re;     // read request
    logic                  wp;     // write protect, writes dropped while high
    logic [ADDR_WIDTH-1:0] addr;   // bus address
    logic [WIDTH-1:0]      din;    // write data
    logic                  valid;  // read data on the shared bus this cycle
    logic                  hit;    // addr falls inside this bank's window
    logic                  busy;   // clear sequencer running
    logic                  err;    // one-cycle pulse on a rejected access

    modport master (
        output we, re, wp, addr, din,
        input  valid, hit, busy, err
    );

    modport slave (
        input  we, re, wp, addr, din,
        output valid, hit, busy, err
    );
endinterface

// File: rtl/mem_bank.sv
// Address-decoded RAM bank for the 6502 system bus.
// - Window [BASE, BASE + DEPTH*MIRRORS) with every DEPTH-sized copy aliasing
//   the same storage.
// - Registered one-cycle reads with a valid strobe; the bank drives the shared
//   data bus only while valid is high, otherwise it floats.
// - After reset a sequencer writes INIT_VAL to every word before any access
//   is accepted.
// - Dynamic write protect; protected writes and accesses during the clear
//   raise a one-cycle err pulse instead of touching state.
module mem_bank #(
    parameter int                    WIDTH      = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
    parameter int                    MIRRORS    = 1,
    parameter logic [WIDTH-1:0]      INIT_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_bank_if.slave        bus,
    output wire [WIDTH-1:0]  dout
);

    localparam int IDX_W = $clog2(DEPTH);

    // Window bounds carry one extra bit so a window ending at the top of the
    // address space does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] WIN_LO   = {1'b0, BASE};
    localparam logic [ADDR_WIDTH:0] WIN_SPAN = (ADDR_WIDTH + 1)'(DEPTH * MIRRORS);
    localparam logic [ADDR_WIDTH:0] WIN_HI   = WIN_LO + WIN_SPAN;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic [ADDR_WIDTH:0]  addr_ext;
    logic [IDX_W-1:0]     local_idx;
    logic                 hit;

    logic                 mem_we;
    logic [IDX_W-1:0]     mem_widx;
    logic [WIDTH-1:0]     mem_wdata;
    logic                 rd_en;
    logic                 err_d;

    logic                 valid_q;
    logic                 err_q;
    logic [WIDTH-1:0]     rd_q;
    logic [WIDTH-1:0]     mem [DEPTH];

    // Window decode and local word index; the index is the low bits of the
    // offset from BASE, which is what folds the mirrors onto one storage word.
    always_comb begin
        addr_ext  = {1'b0, bus.addr};
        hit       = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
        local_idx = IDX_W'(bus.addr - BASE);
    end

    // Next state, clear pointer and per-cycle access decisions.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_widx  = local_idx;
        mem_wdata = bus.din;
        rd_en     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = ptr_q;
                mem_wdata = INIT_VAL;
                ptr_d     = ptr_q + IDX_W'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                end
                if (hit && (bus.we || bus.re)) begin
                    err_d = 1'b1;
                end
            end

            IDLE: begin
                if (hit && bus.we && bus.wp) begin
                    // A rejected request changes nothing, including any read
                    // issued with it, so err and valid never coincide.
                    err_d = 1'b1;
                end else begin
                    mem_we = hit && bus.we;
                    rd_en  = hit && bus.re;
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Control state and output strobes; reset aborts any clear or access.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= rd_en;
            err_q   <= err_d;
        end
    end

    // Storage and read register; a same-edge read sees the old word.
    // NOTE: the array and read register have no reset; the clear sequencer
    // gives the contents a defined value and dout is masked until valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
        if (rd_en) begin
            rd_q <= mem[local_idx];
        end
    end

    assign bus.hit   = hit;
    assign bus.busy  = (state_q == CLEAR);
    assign bus.valid = valid_q;
    assign bus.err   = err_q;

    // Release the shared data bus whenever this bank is not returning data.
    assign dout = valid_q ? rd_q : {WIDTH{1'bz}};

endmodule
